// File: rtl/dat_mem_pkg.sv
// Shared types and helpers for the stacked data memory.
package dat_mem_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // The stack occupies the top stk_depth words of a 2**aw word array.
    function automatic int unsigned stk_base(input int unsigned aw, input int unsigned stk_depth);
        return (32'd1 << aw) - stk_depth;
    endfunction

endpackage

// File: rtl/mem_clr_seq.sv
// Post-reset clear sequencer: walks every address once, writing zero, while busy is held.
module mem_clr_seq
    import dat_mem_pkg::*;
#(
    parameter int AW             = 8,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);

    state_t        state;
    logic [AW-1:0] clr_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            clr_cnt <= '0;
            if (CLEAR_ON_RESET != 0) begin
                state <= CLEAR;
                busy  <= 1'b1;
            end else begin
                state <= IDLE;
                busy  <= 1'b0;
            end
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == {AW{1'b1}}) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign clr_we   = busy;
    assign clr_addr = clr_cnt;

endmodule

// File: rtl/dat_mem_stk.sv
// Data RAM with combinational read, clocked store port and a hardware stack in the top region.
module dat_mem_stk
    import dat_mem_pkg::*;
#(
    parameter int DW             = 8,
    parameter int AW             = 8,
    parameter int STK_DEPTH      = 16,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] dat_in,
    output logic [DW-1:0] dat_out,
    input  logic          push,
    input  logic          pop,
    output logic [DW-1:0] stk_top,
    output logic [AW:0]   sp,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          unf,
    output logic          busy
);

    localparam int DEPTH = 2 ** AW;
    localparam logic [AW:0] SP_EMPTY = (AW+1)'(DEPTH);
    localparam logic [AW:0] SP_FULL  = (AW+1)'(stk_base(AW, STK_DEPTH));
    localparam logic [AW:0] SP_ONE   = (AW+1)'(1);

    logic [DW-1:0] core [DEPTH];

    logic          clr_we;
    logic [AW-1:0] clr_addr;

    logic          we;
    logic [AW-1:0] wa;
    logic [DW-1:0] wd;
    logic [AW:0]   sp_nxt;
    logic [AW:0]   sp_dec;
    logic          ovf_set;
    logic          unf_set;

    mem_clr_seq #(
        .AW             (AW),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk      (clk),
        .reset    (reset),
        .busy     (busy),
        .clr_we   (clr_we),
        .clr_addr (clr_addr)
    );

    assign full    = (sp == SP_FULL);
    assign empty   = (sp == SP_EMPTY);
    assign dat_out = busy ? '0 : core[addr];
    assign stk_top = (busy || empty) ? '0 : core[sp[AW-1:0]];
    assign sp_dec  = sp - SP_ONE;

    // Single write port: clear beats stack, stack beats the random-access store.
    always_comb begin
        we      = 1'b0;
        wa      = '0;
        wd      = '0;
        sp_nxt  = sp;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (clr_we) begin
            we = 1'b1;
            wa = clr_addr;
        end else begin
            if (push && pop && !empty) begin
                we = 1'b1;
                wa = sp[AW-1:0];
                wd = dat_in;
            end else if (push) begin
                if (!full) begin
                    we     = 1'b1;
                    wa     = sp_dec[AW-1:0];
                    wd     = dat_in;
                    sp_nxt = sp_dec;
                end else begin
                    ovf_set = 1'b1;
                end
            end else if (pop) begin
                if (!empty) sp_nxt = sp + SP_ONE;
                else        unf_set = 1'b1;
            end
            if (!we && wr_en) begin
                we = 1'b1;
                wa = addr;
                wd = dat_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sp  <= SP_EMPTY;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            sp  <= sp_nxt;
            ovf <= ovf | ovf_set;
            unf <= unf | unf_set;
        end
    end

    // The array itself is never reset; only the clear sequence zeroes it.
    always_ff @(posedge clk) begin
        if (we) begin
            core[wa] <= wd;
`ifndef SYNTHESIS
            $display("dat_mem_stk: write core[%0h] <= %0h", wa, wd);
`endif
        end
    end

endmodule
